fft_output_reorder: RTL and testbench
=====================================

FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning FFT points per frame.
REQ-002 The block SHALL have parameter DATA_W, default 18, meaning the complex component width, which equals the final butterfly stage output width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port valid_i, input, 1 bit: the current data_in sample is valid.
REQ-006 The block SHALL have port data_in_r, input, DATA_W bits, signed: real part, arriving in bit-reversed frequency order.
REQ-007 The block SHALL have port data_in_i, input, DATA_W bits, signed: imaginary part.
REQ-008 The block SHALL have port valid_o, output, 1 bit: the data_out sample is valid.
REQ-009 The block SHALL have port frame_o, output, 1 bit: a one-cycle pulse coincident with output bin 0.
REQ-010 The block SHALL have port bin_o, output, log2(N) bits: the frequency index of the current output.
REQ-011 The block SHALL have ports data_out_r and data_out_i, each output, DATA_W bits, signed: X[bin_o] in natural order.

Function
REQ-012 Samples SHALL be accepted only on edges where valid_i=1; gaps of any length between valid samples SHALL be tolerated, with no bubble limit.
REQ-013 Each N accepted samples SHALL form one frame; the 5-bit write counter SHALL wrap from N-1 to 0 and toggle the write bank.
REQ-014 The n-th accepted sample of a frame SHALL be written to address bitrev(n) of the current write bank; for N=32, bitrev reverses 5 bits.
REQ-015 Storage SHALL be ping-pong: 2 banks x N entries x 2*DATA_W bits.
REQ-016 The edge that writes sample N-1 SHALL mark that bank full.
REQ-017 The read side SHALL have two states, IDLE and READ.
REQ-018 IDLE SHALL go to READ when a full bank is pending; READ SHALL go to IDLE after bin N-1 unless the other bank is already full, in which case it SHALL stay in READ with no gap.
REQ-019 In READ, the block SHALL output one sample per cycle, addresses 0..N-1 sequentially, as registered outputs.
REQ-020 Latency: valid_o SHALL rise on the first edge after the edge that wrote sample N-1, and SHALL stay high for exactly N cycles per frame.
REQ-021 bin_o SHALL equal the read address; frame_o SHALL be 1 only when valid_o=1 and bin_o=0.
REQ-022 When valid_o=0, data_out_r/i SHALL be 0, bin_o SHALL be 0, and frame_o SHALL be 0.
REQ-023 Data SHALL pass through bit-exact, with no scaling, rounding or sign change.
REQ-024 A bank write and a read of the other bank SHALL be permitted on the same edge.
REQ-025 A bank SHALL be released on the edge that reads bin N-1.
REQ-026 Overflow (both banks full while a third frame completes) SHALL be impossible at an input rate of at most 1 sample per cycle, and SHALL not require handling.
REQ-027 An SVA SHALL flag any write into a bank that is not released.

Reset
REQ-028 On rst_n=0, the block SHALL immediately clear the write counter, bank pointers, full flags and read state to IDLE.
REQ-029 On rst_n=0, the block SHALL force valid_o=0, frame_o=0, bin_o=0 and data_out=0.
REQ-030 Reset mid-frame or mid-read SHALL discard all partial and buffered frames, and SHALL not emit any post-reset output until N new samples are accepted.
REQ-031 The bank memory contents SHALL not need to be reset.

Structure
REQ-032 N, log2(N), DATA_W and the bitrev function SHALL live in the shared FFT package, used by all stages.
REQ-033 The block SHALL use one sub-module, reorder_bank: a 2-bank register array with one synchronous write port and one registered read port.
REQ-034 The control counters and FSM SHALL reside in fft_output_reorder.

Verification
REQ-035 Ordering: one frame with data_in_r=n, data_in_i=-n for n=0..31 -> outputs data_out_r = 0,16,8,24,4,20,12,28,2,..,31 with data_in_i negated; frame_o on the first output only; bin_o = 0..31.
REQ-036 Back-to-back: 3 contiguous frames -> valid_o high for 96 consecutive cycles, and frame_o pulses exactly 32 cycles apart.
REQ-037 Gapped input: valid_i toggles 1,0 per cycle for 64 cycles -> exactly one frame is output, valid_o rises 1 cycle after the 32nd sample, and the order matches REQ-035.
REQ-038 Reset mid-frame: rst_n asserted after 20 samples, then 32 new samples -> exactly one output frame containing only post-reset data.
REQ-039 Reset during READ at bin 10 -> valid_o=0 on the same cycle; no remaining bins are output.
REQ-040 Extremes: inputs +131071 and -131072 -> outputs are bit-identical, and valid_o=0 outputs are zero throughout.

Source files
------------

// File: rtl/fft_output_reorder_pkg.sv
// Shared FFT constants, read-side state encoding and the bit-reversal helper
// used by every stage that has to undo decimation-in-frequency ordering.
package fft_output_reorder_pkg;

    localparam int FFT_N      = 32;
    localparam int FFT_LOG2N  = $clog2(FFT_N);
    localparam int FFT_DATA_W = 18;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Reverses the low 'bits' bits of value; bits above 'bits' come back zero.
    function automatic logic [15:0] bitrev(input logic [15:0] value, input int bits);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < bits) r[k] = value[bits-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// Sample stream into and out of the output reorder buffer.
// Handshake: valid-only, no back-pressure; a sample moves on every rising clk edge where its valid is 1.
interface fft_output_reorder_if #(
    parameter int N      = fft_output_reorder_pkg::FFT_N,
    parameter int DATA_W = fft_output_reorder_pkg::FFT_DATA_W
);
    localparam int AW = $clog2(N);

    logic                     valid_i;
    logic signed [DATA_W-1:0] data_in_r;
    logic signed [DATA_W-1:0] data_in_i;
    logic                     valid_o;
    logic                     frame_o;
    logic [AW-1:0]            bin_o;
    logic signed [DATA_W-1:0] data_out_r;
    logic signed [DATA_W-1:0] data_out_i;

    modport master (
        output valid_i, data_in_r, data_in_i,
        input  valid_o, frame_o, bin_o, data_out_r, data_out_i
    );

    modport slave (
        input  valid_i, data_in_r, data_in_i,
        output valid_o, frame_o, bin_o, data_out_r, data_out_i
    );

endinterface

// File: rtl/fft_output_reorder_bank.sv
// Two-bank ping-pong sample store: one synchronous write port and one
// registered read port that returns zero whenever no read is issued.
module reorder_bank #(
    parameter int N = 32,
    parameter int W = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_bank,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic                 rd_en,
    input  logic                 rd_bank,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic [W-1:0]         rd_data
);
    logic [W-1:0] mem [2*N];

    // Contents are never reset; the full flags decide what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/fft_output_reorder.sv
// Converts bit-reversed FFT output into natural bin order using a ping-pong
// buffer: frames are scattered in at bitrev(n) and streamed out sequentially.
module fft_output_reorder
    import fft_output_reorder_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_output_reorder_if.slave io,
    output rd_state_e           dbg_state
);
    localparam int            AW   = $clog2(N);
    localparam int            MW   = 2 * DATA_W;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic [AW-1:0] wr_cnt;
    logic          wr_bank;
    logic [1:0]    full;
    logic          rd_bank;
    logic [AW-1:0] rd_cnt;
    rd_state_e     state;
    logic          valid_q;
    logic          frame_q;
    logic [AW-1:0] bin_q;

    logic          wr_last;
    logic          rd_en;
    logic          rd_last;
    logic          other_full;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] rd_data;

    assign wr_last = io.valid_i && (wr_cnt == LAST);
    assign wr_addr = AW'(bitrev(16'(wr_cnt), AW));

    // Bin 0 is read on the very edge the FSM leaves IDLE, so the first output
    // appears one edge after the bank fills.
    assign rd_en   = (state == RD_READ) || full[rd_bank];
    assign rd_addr = (state == RD_READ) ? rd_cnt : '0;
    assign rd_last = rd_en && (rd_addr == LAST);

    // A bank completing on this edge counts as full so back-to-back frames leave no gap.
    assign other_full = full[~rd_bank] || (wr_last && (wr_bank != rd_bank));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (io.valid_i) begin
            if (wr_last) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (rd_last) full[rd_bank] <= 1'b0;
            if (wr_last) full[wr_bank] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RD_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            bin_q   <= '0;
        end else begin
            valid_q <= rd_en;
            frame_q <= rd_en && (rd_addr == '0);
            bin_q   <= rd_en ? rd_addr : '0;
            case (state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        state  <= RD_READ;
                        rd_cnt <= AW'(1);
                    end
                end
                RD_READ: begin
                    if (rd_cnt == LAST) begin
                        rd_cnt  <= '0;
                        rd_bank <= ~rd_bank;
                        if (!other_full) state <= RD_IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    reorder_bank #(
        .N(N),
        .W(MW)
    ) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (io.valid_i),
        .wr_bank(wr_bank),
        .wr_addr(wr_addr),
        .wr_data({io.data_in_r, io.data_in_i}),
        .rd_en  (rd_en),
        .rd_bank(rd_bank),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    assign io.valid_o    = valid_q;
    assign io.frame_o    = frame_q;
    assign io.bin_o      = bin_q;
    assign io.data_out_r = rd_data[MW-1:DATA_W];
    assign io.data_out_i = rd_data[DATA_W-1:0];
    assign dbg_state     = state;

    // Writing into a bank that still holds an unread frame would corrupt it.
    a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
        io.valid_i |-> !full[wr_bank]);

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for the output reorder buffer: ordering, back-to-back,
// gapped input, reset mid-frame / mid-read and full-scale data.
module tb_fft_output_reorder;
    import fft_output_reorder_pkg::*;

    localparam int N  = 32;
    localparam int DW = 18;
    localparam int AW = 5;
    localparam int EW = AW + 2 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_output_reorder_if #(.N(N), .DATA_W(DW)) io ();
    rd_state_e dbg_state;

    fft_output_reorder #(.N(N), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io       (io.slave),
        .dbg_state(dbg_state)
    );

    // Natural bin k holds the sample that arrived as number ord[k].
    int ord[32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                    1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_count = 0;
    int run_len = 0;
    int last_run = 0;
    int rise_cyc = 0;
    int frame_cyc_q[$];
    logic prev_valid = 1'b0;
    int last_samp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int samp_r(input int mode, input int base, input int n);
        if (mode == 1) return (n % 2 == 0) ? 131071 : -131072;
        return base + n;
    endfunction

    function automatic int samp_i(input int mode, input int base, input int n);
        if (mode == 1) return (n % 2 == 0) ? -131072 : 131071;
        return -(base + n);
    endfunction

    // Scoreboard: pops one expectation per valid output, checks idle zeros otherwise.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n) begin
            if (io.valid_o) begin
                if (!prev_valid) rise_cyc = cyc;
                run_len++;
                out_count++;
                if (io.frame_o) frame_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("bin_data", 64'({io.bin_o, io.data_out_r, io.data_out_i}), 64'(e));
                    check("frame_o", 64'(io.frame_o), 64'(e[EW-1 -: AW] == '0));
                end
            end else begin
                if (prev_valid) last_run = run_len;
                run_len = 0;
                check("idle_zero", 64'({io.frame_o, io.bin_o, io.data_out_r, io.data_out_i}), 64'(0));
            end
            prev_valid = io.valid_o;
        end else begin
            prev_valid = 1'b0;
            run_len = 0;
        end
    end

    task automatic drive(input logic v, input int r, input int i);
        io.valid_i   = v;
        io.data_in_r = DW'(r);
        io.data_in_i = DW'(i);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int mode, input int base);
        for (int k = 0; k < N; k++) begin
            exp_q.push_back({AW'(k), DW'(samp_r(mode, base, ord[k])), DW'(samp_i(mode, base, ord[k]))});
        end
    endtask

    task automatic send_frame(input int mode, input int base, input bit gapped);
        expect_frame(mode, base);
        for (int n = 0; n < N; n++) begin
            drive(1'b1, samp_r(mode, base, n), samp_i(mode, base, n));
            if (n == N - 1) last_samp_cyc = cyc;
            if (gapped) drive(1'b0, 0, 0);
        end
        io.valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 200;
        while ((exp_q.size() != 0 || io.valid_o) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(tag, 64'(budget > 0), 64'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        io.valid_i = 1'b0;
        io.data_in_r = '0;
        io.data_in_i = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int f0;
        int budget;
        bit found;

        io.valid_i   = 1'b0;
        io.data_in_r = '0;
        io.data_in_i = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_valid_o", 64'(io.valid_o), 64'(0));
        check("rst_frame_o", 64'(io.frame_o), 64'(0));
        check("rst_bin_o", 64'(io.bin_o), 64'(0));
        check("rst_data", 64'({io.data_out_r, io.data_out_i}), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(RD_IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ordering: data_r = n, data_i = -n
        c0 = out_count;
        f0 = frame_cyc_q.size();
        send_frame(0, 0, 1'b0);
        wait_drain("t2_drain");
        check("t2_count", 64'(out_count - c0), 64'(32));
        check("t2_frames", 64'(frame_cyc_q.size() - f0), 64'(1));
        check("t2_latency", 64'(rise_cyc - last_samp_cyc), 64'(1));
        check("t2_run", 64'(last_run), 64'(32));

        // Three contiguous frames
        c0 = out_count;
        f0 = frame_cyc_q.size();
        send_frame(0, 1000, 1'b0);
        send_frame(0, 2000, 1'b0);
        send_frame(0, 3000, 1'b0);
        wait_drain("t3_drain");
        check("t3_count", 64'(out_count - c0), 64'(96));
        check("t3_run", 64'(last_run), 64'(96));
        check("t3_frames", 64'(frame_cyc_q.size() - f0), 64'(3));
        if (frame_cyc_q.size() >= f0 + 3) begin
            check("t3_gap1", 64'(frame_cyc_q[f0+1] - frame_cyc_q[f0]), 64'(32));
            check("t3_gap2", 64'(frame_cyc_q[f0+2] - frame_cyc_q[f0+1]), 64'(32));
        end

        // Gapped input: valid_i alternates 1,0
        c0 = out_count;
        f0 = frame_cyc_q.size();
        send_frame(0, 4000, 1'b1);
        wait_drain("t4_drain");
        check("t4_count", 64'(out_count - c0), 64'(32));
        check("t4_frames", 64'(frame_cyc_q.size() - f0), 64'(1));
        check("t4_latency", 64'(rise_cyc - last_samp_cyc), 64'(1));
        check("t4_run", 64'(last_run), 64'(32));

        // Reset after 20 samples, then a fresh frame
        c0 = out_count;
        for (int n = 0; n < 20; n++) drive(1'b1, samp_r(0, 5000, n), samp_i(0, 5000, n));
        apply_reset();
        check("t5_no_partial", 64'(out_count - c0), 64'(0));
        send_frame(0, 6000, 1'b0);
        wait_drain("t5_drain");
        check("t5_count", 64'(out_count - c0), 64'(32));

        // Reset while bin 10 is on the output
        c0 = out_count;
        send_frame(0, 7000, 1'b0);
        budget = 100;
        found = 1'b0;
        while (!found && budget > 0) begin
            @(negedge clk);
            if (io.valid_o && io.bin_o == AW'(10)) found = 1'b1;
            budget--;
        end
        check("t6_reach_bin10", 64'(found), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_now", 64'(io.valid_o), 64'(0));
        check("t6_outputs_now", 64'({io.frame_o, io.bin_o, io.data_out_r, io.data_out_i}), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("t6_count", 64'(out_count - c0), 64'(11));
        check("t6_state", 64'(dbg_state), 64'(RD_IDLE));

        // Full-scale extremes
        c0 = out_count;
        send_frame(1, 0, 1'b0);
        wait_drain("t7_drain");
        check("t7_count", 64'(out_count - c0), 64'(32));
        check("t7_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
